// File: rtl/add_sub_exp_align_pipe.sv
// Two-stage operand alignment for the FPU add/sub path: magnitude compare and swap,
// then right-shift of the smaller mantissa into a {man, G, R, S} field.
module add_sub_exp_align_pipe #(
  parameter int unsigned SIZE_EXP = 8,
  parameter int unsigned SIZE_MAN = 24
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [SIZE_EXP-1:0]   i_exp_a,
  input  logic [SIZE_EXP-1:0]   i_exp_b,
  input  logic [SIZE_MAN-1:0]   i_man_a,
  input  logic [SIZE_MAN-1:0]   i_man_b,
  input  logic                  i_sign_a,
  input  logic                  i_sign_b,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [SIZE_EXP-1:0]   o_exp_max,
  output logic [SIZE_MAN-1:0]   o_man_big,
  output logic [SIZE_MAN+2:0]   o_man_small_al,
  output logic                  o_sign_big,
  output logic                  o_sign_small,
  output logic                  o_swap,
  output logic [SIZE_EXP-1:0]   o_exp_diff
);

  localparam int unsigned SIZE_EXT = SIZE_MAN + 3;

  logic                w_a_less;
  logic                w_adv1;
  logic                w_adv2;
  logic                w_acc1;
  logic                w_ld2;

  logic                r_v1;
  logic                r_swap1;
  logic [SIZE_EXP-1:0] r_exp_max1;
  logic [SIZE_EXP-1:0] r_diff1;
  logic [SIZE_MAN-1:0] r_man_big1;
  logic [SIZE_MAN-1:0] r_man_small1;
  logic                r_sign_big1;
  logic                r_sign_small1;

  logic                r_v2;
  logic                r_swap2;
  logic [SIZE_EXP-1:0] r_exp_max2;
  logic [SIZE_EXP-1:0] r_diff2;
  logic [SIZE_MAN-1:0] r_man_big2;
  logic [SIZE_EXT-1:0] r_man_small_al2;
  logic                r_sign_big2;
  logic                r_sign_small2;

  logic [SIZE_EXT-1:0] w_ext;
  logic [SIZE_EXT-1:0] w_shifted;
  logic [SIZE_EXT-1:0] w_lost_mask;
  logic [SIZE_EXT-1:0] w_aligned;
  logic                w_in_range;

  // Equal magnitudes keep A on the big lane.
  assign w_a_less = (i_exp_a < i_exp_b) | ((i_exp_a == i_exp_b) & (i_man_a < i_man_b));

  assign w_adv2  = ~r_v2 | i_ready;
  assign w_adv1  = ~r_v1 | w_adv2;
  assign o_ready = w_adv1;
  assign w_acc1  = i_valid & w_adv1;
  assign w_ld2   = r_v1 & w_adv2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_v1          <= 1'b0;
      r_swap1       <= 1'b0;
      r_exp_max1    <= '0;
      r_diff1       <= '0;
      r_man_big1    <= '0;
      r_man_small1  <= '0;
      r_sign_big1   <= 1'b0;
      r_sign_small1 <= 1'b0;
    end else begin
      if (w_adv1) begin
        r_v1 <= i_valid;
      end
      if (w_acc1) begin
        r_swap1 <= w_a_less;
        if (w_a_less) begin
          r_exp_max1    <= i_exp_b;
          r_diff1       <= i_exp_b - i_exp_a;
          r_man_big1    <= i_man_b;
          r_man_small1  <= i_man_a;
          r_sign_big1   <= i_sign_b;
          r_sign_small1 <= i_sign_a;
        end else begin
          r_exp_max1    <= i_exp_a;
          r_diff1       <= i_exp_a - i_exp_b;
          r_man_big1    <= i_man_a;
          r_man_small1  <= i_man_b;
          r_sign_big1   <= i_sign_a;
          r_sign_small1 <= i_sign_b;
        end
      end
    end
  end

  // Bits shifted past position 0 collapse into the sticky bit.
  assign w_ext       = {r_man_small1, 3'b000};
  assign w_in_range  = 32'(r_diff1) < SIZE_EXT;
  assign w_shifted   = w_ext >> r_diff1;
  assign w_lost_mask = ~({SIZE_EXT{1'b1}} << r_diff1);

  always_comb begin
    w_aligned = {{(SIZE_EXT-1){1'b0}}, |r_man_small1};
    if (w_in_range) begin
      w_aligned = {w_shifted[SIZE_EXT-1:1], w_shifted[0] | (|(w_ext & w_lost_mask))};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_v2            <= 1'b0;
      r_swap2         <= 1'b0;
      r_exp_max2      <= '0;
      r_diff2         <= '0;
      r_man_big2      <= '0;
      r_man_small_al2 <= '0;
      r_sign_big2     <= 1'b0;
      r_sign_small2   <= 1'b0;
    end else begin
      if (w_adv2) begin
        r_v2 <= r_v1;
      end
      if (w_ld2) begin
        r_swap2         <= r_swap1;
        r_exp_max2      <= r_exp_max1;
        r_diff2         <= r_diff1;
        r_man_big2      <= r_man_big1;
        r_man_small_al2 <= w_aligned;
        r_sign_big2     <= r_sign_big1;
        r_sign_small2   <= r_sign_small1;
      end
    end
  end

  assign o_valid        = r_v2;
  assign o_swap         = r_swap2;
  assign o_exp_max      = r_exp_max2;
  assign o_exp_diff     = r_diff2;
  assign o_man_big      = r_man_big2;
  assign o_man_small_al = r_man_small_al2;
  assign o_sign_big     = r_sign_big2;
  assign o_sign_small   = r_sign_small2;

endmodule

// File: tb/tb_add_sub_exp_align_pipe.sv
// Self-checking bench for add_sub_exp_align_pipe: directed vector table, back-pressure,
// mid-stream reset and a randomized stream against an arithmetic reference model.
module tb_add_sub_exp_align_pipe;

  typedef struct {
    logic        swap;
    logic [7:0]  emax;
    logic [7:0]  diff;
    logic [23:0] mbig;
    logic [26:0] mal;
    logic        sbig;
    logic        ssmall;
  } res_t;

  typedef struct {
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic [23:0] ma;
    logic [23:0] mb;
    logic        sa;
    logic        sb;
    res_t        exp;
  } vec_t;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [7:0]  i_exp_a, i_exp_b;
  logic [23:0] i_man_a, i_man_b;
  logic        i_sign_a, i_sign_b;
  logic        o_valid;
  logic        i_ready;
  logic [7:0]  o_exp_max;
  logic [23:0] o_man_big;
  logic [26:0] o_man_small_al;
  logic        o_sign_big, o_sign_small, o_swap;
  logic [7:0]  o_exp_diff;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pop    = 0;
  logic last_acc;
  logic saw_not_ready;
  res_t sb_q[$];
  vec_t vt[10];

  add_sub_exp_align_pipe #(.SIZE_EXP(8), .SIZE_MAN(24)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_exp_a        (i_exp_a),
    .i_exp_b        (i_exp_b),
    .i_man_a        (i_man_a),
    .i_man_b        (i_man_b),
    .i_sign_a       (i_sign_a),
    .i_sign_b       (i_sign_b),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_exp_max      (o_exp_max),
    .o_man_big      (o_man_big),
    .o_man_small_al (o_man_small_al),
    .o_sign_big     (o_sign_big),
    .o_sign_small   (o_sign_small),
    .o_swap         (o_swap),
    .o_exp_diff     (o_exp_diff)
  );

  always #5 i_clk = ~i_clk;

  // Reference: magnitude as one integer, alignment as division with remainder-as-sticky.
  function automatic res_t model(input logic [7:0] ea, input logic [7:0] eb,
                                 input logic [23:0] ma, input logic [23:0] mb,
                                 input logic sa, input logic sb);
    res_t   r;
    longint mag_a, mag_b, num, den, q;
    int     d;
    logic [23:0] msmall;
    mag_a = longint'(ea) * 64'd16777216 + longint'(ma);
    mag_b = longint'(eb) * 64'd16777216 + longint'(mb);
    r.swap = mag_a < mag_b;
    if (r.swap) begin
      r.emax = eb; d = int'(eb) - int'(ea); r.mbig = mb; msmall = ma;
      r.sbig = sb; r.ssmall = sa;
    end else begin
      r.emax = ea; d = int'(ea) - int'(eb); r.mbig = ma; msmall = mb;
      r.sbig = sa; r.ssmall = sb;
    end
    r.diff = 8'(d);
    if (d < 27) begin
      num = longint'(msmall) * 8;
      den = longint'(1) << d;
      q   = num / den;
      if (num % den != 0) q = q | 1;
      r.mal = 27'(q);
    end else begin
      r.mal = (msmall != 0) ? 27'd1 : 27'd0;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic chk_res(input string tag, input res_t e);
    chk({tag, ".swap"},   64'(o_swap),         64'(e.swap));
    chk({tag, ".emax"},   64'(o_exp_max),      64'(e.emax));
    chk({tag, ".diff"},   64'(o_exp_diff),     64'(e.diff));
    chk({tag, ".mbig"},   64'(o_man_big),      64'(e.mbig));
    chk({tag, ".mal"},    64'(o_man_small_al), 64'(e.mal));
    chk({tag, ".sbig"},   64'(o_sign_big),     64'(e.sbig));
    chk({tag, ".ssmall"}, 64'(o_sign_small),   64'(e.ssmall));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".valid"}, 64'(o_valid), 64'd0);
    chk({tag, ".data"},
        {o_swap, o_exp_max, o_exp_diff, o_man_big, o_man_small_al, o_sign_big, o_sign_small},
        64'd0);
  endtask

  task automatic set_in(input vec_t v);
    i_exp_a = v.ea; i_exp_b = v.eb; i_man_a = v.ma; i_man_b = v.mb;
    i_sign_a = v.sa; i_sign_b = v.sb;
  endtask

  function automatic vec_t mk(input logic [7:0] ea, input logic [7:0] eb,
                              input logic [23:0] ma, input logic [23:0] mb,
                              input logic sa, input logic sb, input logic swap,
                              input logic [7:0] emax, input logic [7:0] diff,
                              input logic [23:0] mbig, input logic [26:0] mal,
                              input logic sbig, input logic ssmall);
    vec_t v;
    v.ea = ea; v.eb = eb; v.ma = ma; v.mb = mb; v.sa = sa; v.sb = sb;
    v.exp.swap = swap; v.exp.emax = emax; v.exp.diff = diff; v.exp.mbig = mbig;
    v.exp.mal = mal; v.exp.sbig = sbig; v.exp.ssmall = ssmall;
    return v;
  endfunction

  // One cycle with scoreboard tracking; inputs are set by the caller at the negedge.
  task automatic step();
    #1;
    if (!o_ready) saw_not_ready = 1'b1;
    chk("o_ready", 64'(o_ready), 64'(!(sb_q.size() == 2 && !i_ready)));
    if (o_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_valid: got o_valid=1 expected nothing in flight");
      end else begin
        chk_res("stream", sb_q[0]);
        if (i_ready) begin
          void'(sb_q.pop_front());
          n_pop++;
        end
      end
    end
    last_acc = i_valid && o_ready;
    if (last_acc) sb_q.push_back(model(i_exp_a, i_exp_b, i_man_a, i_man_b, i_sign_a, i_sign_b));
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic rand_in();
    logic [7:0] ea;
    ea = 8'($urandom_range(0, 255));
    i_exp_a = ea;
    case ($urandom_range(0, 3))
      0: i_exp_b = ea;
      1: i_exp_b = ea + 8'($urandom_range(0, 30));
      2: i_exp_b = ea - 8'($urandom_range(0, 30));
      default: i_exp_b = 8'($urandom_range(0, 255));
    endcase
    i_man_a = ($urandom_range(0, 7) == 0) ? 24'($urandom) : {1'b1, 23'($urandom)};
    i_man_b = ($urandom_range(0, 5) == 0) ? i_man_a : {1'b1, 23'($urandom)};
    i_sign_a = 1'($urandom);
    i_sign_b = 1'($urandom);
  endtask

  initial begin
    vt[0] = mk(130, 127, 24'h800000, 24'hC00000, 0, 1, 0, 130, 3,   24'h800000, 27'h0C00000, 0, 1);
    vt[1] = mk(100, 101, 24'h800001, 24'h900000, 0, 1, 1, 101, 1,   24'h900000, 27'h2000004, 1, 0);
    vt[2] = mk(127, 127, 24'h800000, 24'h800001, 1, 0, 1, 127, 0,   24'h800001, 27'h4000000, 0, 1);
    vt[3] = mk(127, 127, 24'hABCDEF, 24'hABCDEF, 0, 1, 0, 127, 0,   24'hABCDEF, 27'h55E6F78, 0, 1);
    vt[4] = mk(200, 160, 24'h800000, 24'h800000, 1, 0, 0, 200, 40,  24'h800000, 27'h0000001, 1, 0);
    vt[5] = mk(153, 127, 24'h800000, 24'h800000, 0, 0, 0, 153, 26,  24'h800000, 27'h0000001, 0, 0);
    vt[6] = mk(127, 153, 24'h000001, 24'hFFFFFF, 0, 1, 1, 153, 26,  24'hFFFFFF, 27'h0000001, 1, 0);
    vt[7] = mk(10,  37,  24'h000000, 24'h800000, 1, 1, 1, 37,  27,  24'h800000, 27'h0000000, 1, 1);
    vt[8] = mk(152, 127, 24'hC00000, 24'hC00000, 0, 1, 0, 152, 25,  24'hC00000, 27'h0000003, 0, 1);
    vt[9] = mk(255, 0,   24'hFFFFFF, 24'hFFFFFF, 0, 0, 0, 255, 255, 24'hFFFFFF, 27'h0000001, 0, 0);

    i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    set_in(vt[0]);
    saw_not_ready = 1'b0;
    #3;
    chk_zero("reset");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    chk("reset.o_ready", 64'(o_ready), 64'd1);
    @(negedge i_clk);

    // Directed table: one pair at a time, exact two-cycle latency, no duplicate.
    for (int i = 0; i < 10; i++) begin
      set_in(vt[i]);
      i_valid = 1'b1;
      @(posedge i_clk);
      @(negedge i_clk);
      i_valid = 1'b0;
      chk($sformatf("vec%0d.early_valid", i), 64'(o_valid), 64'd0);
      @(posedge i_clk);
      @(negedge i_clk);
      chk($sformatf("vec%0d.valid", i), 64'(o_valid), 64'd1);
      chk_res($sformatf("vec%0d", i), vt[i].exp);
      @(posedge i_clk);
      @(negedge i_clk);
      chk($sformatf("vec%0d.dup_valid", i), 64'(o_valid), 64'd0);
    end

    // Back-pressure: four pairs, ready held low for three cycles once o_valid rises.
    begin
      int k = 0;
      int stall = 0;
      logic stall_done = 1'b0;
      n_pop = 0;
      saw_not_ready = 1'b0;
      for (int c = 0; c < 20; c++) begin
        if (o_valid && !stall_done) begin
          stall = 3;
          stall_done = 1'b1;
        end
        i_ready = (stall == 0);
        i_valid = (k < 4);
        set_in(vt[k % 10]);
        step();
        if (last_acc) k++;
        if (stall > 0) stall--;
      end
      i_valid = 1'b0; i_ready = 1'b1;
      chk("bp.pairs_out", 64'(n_pop), 64'd4);
      chk("bp.ready_dropped", 64'(saw_not_ready), 64'd1);
      chk("bp.drained", 64'(sb_q.size()), 64'd0);
    end

    // Reset with both stages occupied.
    i_ready = 1'b0;
    i_valid = 1'b1;
    set_in(vt[5]);
    step();
    set_in(vt[6]);
    step();
    i_valid = 1'b0;
    chk("mrst.full_valid", 64'(o_valid), 64'd1);
    i_rst_n = 1'b0;
    #1;
    chk_zero("mrst");
    sb_q.delete();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    #1;
    chk("mrst.o_ready", 64'(o_ready), 64'd1);
    set_in(vt[4]);
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    chk("mrst.early_valid", 64'(o_valid), 64'd0);
    step();
    chk("mrst.latency", 64'(o_valid), 64'd1);
    step();
    chk("mrst.drained", 64'(sb_q.size()), 64'd0);

    // Randomized stream with random back-pressure.
    for (int c = 0; c < 1500; c++) begin
      i_valid = ($urandom_range(0, 3) != 0);
      i_ready = ($urandom_range(0, 3) != 0);
      rand_in();
      step();
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int c = 0; c < 6; c++) step();
    chk("rand.drained", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
